// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, field positions, exception codes.
package cp0_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned REG_W  = 5;
   localparam int unsigned EXC_W  = 5;
   localparam int unsigned IM_W   = 6;

   // CP0 register numbers
   localparam logic [REG_W-1:0] REG_SR    = 5'd12;
   localparam logic [REG_W-1:0] REG_CAUSE = 5'd13;
   localparam logic [REG_W-1:0] REG_EPC   = 5'd14;
   localparam logic [REG_W-1:0] REG_PRID  = 5'd15;

   // SR field positions
   localparam int unsigned SR_IE_BIT  = 0;
   localparam int unsigned SR_EXL_BIT = 1;
   localparam int unsigned SR_IM_LO   = 10;

   // Cause field positions
   localparam int unsigned CAUSE_EXC_LO = 2;
   localparam int unsigned CAUSE_IP_LO  = 10;
   localparam int unsigned CAUSE_BD_BIT = 31;

   // Exception codes (Cause.ExcCode)
   localparam logic [EXC_W-1:0] EXC_INT  = 5'd0;
   localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
   localparam logic [EXC_W-1:0] EXC_ADES = 5'd5;
   localparam logic [EXC_W-1:0] EXC_RI   = 5'd10;
   localparam logic [EXC_W-1:0] EXC_OV   = 5'd12;

   // Processor identification, hard-wired
   localparam logic [DATA_W-1:0] PRID_VALUE = 32'h0000_1234;

   // EPC is always word aligned
   localparam logic [DATA_W-1:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

   // Word-align an address by clearing the two low bits
   function automatic logic [DATA_W-1:0] word_align(input logic [DATA_W-1:0] addr);
      return addr & WORD_ALIGN_MASK;
   endfunction

endpackage

// File: rtl/cp0_handler.sv
// CP0 exception/interrupt handler: SR, Cause, EPC, PRId with M-stage capture.
module cp0_handler
   import cp0_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic [DATA_W-1:0]   pc_m,
   input  logic [EXC_W-1:0]    excode_m,
   input  logic                bd_m,
   input  logic [IM_W-1:0]     hwint,
   input  logic                we,
   input  logic [REG_W-1:0]    a1,
   input  logic [REG_W-1:0]    a2,
   input  logic [DATA_W-1:0]   din,
   input  logic                eret_m,
   output logic [DATA_W-1:0]   dout,
   output logic [DATA_W-1:0]   epc_out,
   output logic                int_req
);

   // SR fields
   logic [IM_W-1:0]   sr_im;
   logic              sr_exl;
   logic              sr_ie;

   // Cause fields
   logic              cause_bd;
   logic [IM_W-1:0]   cause_ip;
   logic [EXC_W-1:0]  cause_exc;

   // Exception program counter
   logic [DATA_W-1:0] epc;

   logic              int_pending;
   logic              exc_pending;
   logic              mtc0_en;
   logic [DATA_W-1:0] pc_victim;
   logic [DATA_W-1:0] sr_value;
   logic [DATA_W-1:0] cause_value;

   // Pending-event detection and the zero-latency take-exception request
   always_comb begin
      int_pending = (|(hwint & sr_im)) & sr_ie & ~sr_exl;
      exc_pending = (excode_m != EXC_INT) & ~sr_exl;
      int_req     = ~reset & (int_pending | exc_pending);
      mtc0_en     = we & ~int_req;
      pc_victim   = word_align(bd_m ? (pc_m - 32'd4) : pc_m);
   end

   // SR: exception entry sets EXL, eret clears it, mtc0 writes IM/EXL/IE
   always_ff @(posedge clk) begin
      if (reset) begin
         sr_im  <= '0;
         sr_exl <= 1'b0;
         sr_ie  <= 1'b0;
      end else if (int_req) begin
         sr_exl <= 1'b1;
      end else if (eret_m) begin
         sr_exl <= 1'b0;
      end else if (mtc0_en && (a2 == REG_SR)) begin
         sr_im  <= din[SR_IM_LO +: IM_W];
         sr_exl <= din[SR_EXL_BIT];
         sr_ie  <= din[SR_IE_BIT];
      end
   end

   // Cause: IP follows hwint every edge; BD/ExcCode captured on exception entry
   always_ff @(posedge clk) begin
      if (reset) begin
         cause_bd  <= 1'b0;
         cause_ip  <= '0;
         cause_exc <= EXC_INT;
      end else begin
         cause_ip <= hwint;
         if (int_req) begin
            cause_bd  <= bd_m;
            cause_exc <= int_pending ? EXC_INT : excode_m;
         end
      end
   end

   // EPC: capture the victim PC on exception entry, else accept mtc0
   always_ff @(posedge clk) begin
      if (reset) begin
         epc <= '0;
      end else if (int_req) begin
         epc <= pc_victim;
      end else if (mtc0_en && (a2 == REG_EPC)) begin
         epc <= word_align(din);
      end
   end

   // Architectural views of SR and Cause; unimplemented bits read zero
   always_comb begin
      sr_value                              = '0;
      sr_value[SR_IM_LO +: IM_W]            = sr_im;
      sr_value[SR_EXL_BIT]                  = sr_exl;
      sr_value[SR_IE_BIT]                   = sr_ie;

      cause_value                           = '0;
      cause_value[CAUSE_BD_BIT]             = cause_bd;
      cause_value[CAUSE_IP_LO +: IM_W]      = cause_ip;
      cause_value[CAUSE_EXC_LO +: EXC_W]    = cause_exc;
   end

   // mfc0 read port; reflects register state before this cycle's edge
   always_comb begin
      dout = '0;
      case (a1)
         REG_SR:    dout = sr_value;
         REG_CAUSE: dout = cause_value;
         REG_EPC:   dout = epc;
         REG_PRID:  dout = PRID_VALUE;
         default:   dout = '0;
      endcase
   end

   assign epc_out = epc;

endmodule

// File: tb/tb_cp0_handler.sv
// Scoreboard bench for cp0_handler: directed cycles push expectations, a monitor checks.
module tb_cp0_handler;

   logic        clk;
   logic        reset;
   logic [31:0] pc_m;
   logic [4:0]  excode_m;
   logic        bd_m;
   logic [5:0]  hwint;
   logic        we;
   logic [4:0]  a1;
   logic [4:0]  a2;
   logic [31:0] din;
   logic        eret_m;
   logic [31:0] dout;
   logic [31:0] epc_out;
   logic        int_req;

   typedef struct {
      string       name;
      int          sel;   // 0 = int_req, 1 = dout, 2 = epc_out
      logic [31:0] value;
   } exp_t;

   exp_t scb[$];
   int   checks = 0;
   int   errors = 0;

   cp0_handler dut (
      .clk      (clk),
      .reset    (reset),
      .pc_m     (pc_m),
      .excode_m (excode_m),
      .bd_m     (bd_m),
      .hwint    (hwint),
      .we       (we),
      .a1       (a1),
      .a2       (a2),
      .din      (din),
      .eret_m   (eret_m),
      .dout     (dout),
      .epc_out  (epc_out),
      .int_req  (int_req)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: on each falling edge pop every queued expectation and compare
   always @(negedge clk) begin
      while (scb.size() > 0) begin
         exp_t e;
         logic [31:0] act;
         e = scb.pop_front();
         case (e.sel)
            0:       act = {31'd0, int_req};
            1:       act = dout;
            default: act = epc_out;
         endcase
         checks++;
         if (act !== e.value) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", e.name, act, e.value, $time);
         end
      end
   end

   task automatic expect_val(input string name, input int sel, input logic [31:0] value);
      exp_t e;
      e.name  = name;
      e.sel   = sel;
      e.value = value;
      scb.push_back(e);
   endtask

   task automatic quiet();
      reset = 0; pc_m = '0; excode_m = '0; bd_m = 0; hwint = '0;
      we = 0; a1 = '0; a2 = '0; din = '0; eret_m = 0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      quiet();
      next_cycle();

      // reset with pending exception and mtc0 must not raise int_req
      reset = 1; excode_m = 5'd4; hwint = 6'h3F; we = 1; a2 = 5'd14; din = 32'hFFFF_FFFF;
      expect_val("int_req_in_reset", 0, 32'd0);
      next_cycle();

      quiet(); a1 = 5'd12;
      expect_val("sr_after_reset", 1, 32'h0);
      expect_val("epc_after_reset", 2, 32'h0);
      expect_val("int_req_idle", 0, 32'd0);
      next_cycle();

      // mtc0 SR = IM[10] | IE
      quiet(); a1 = 5'd13; we = 1; a2 = 5'd12; din = 32'h0000_0401;
      expect_val("cause_after_reset", 1, 32'h0);
      next_cycle();

      // hardware interrupt taken in the same cycle
      quiet(); a1 = 5'd12; hwint = 6'b000001; pc_m = 32'h0000_1000;
      expect_val("sr_written", 1, 32'h0000_0401);
      expect_val("int_req_hwint", 0, 32'd1);
      next_cycle();

      quiet(); a1 = 5'd12; hwint = 6'b000001;
      expect_val("sr_exl_set", 1, 32'h0000_0403);
      expect_val("int_req_masked_exl", 0, 32'd0);
      expect_val("epc_int", 2, 32'h0000_1000);
      next_cycle();

      // exception while EXL is set: no capture
      quiet(); a1 = 5'd13; excode_m = 5'd5;
      expect_val("cause_int", 1, 32'h0000_0400);
      expect_val("int_req_nested", 0, 32'd0);
      next_cycle();

      quiet(); a1 = 5'd13; eret_m = 1;
      expect_val("cause_unchanged", 1, 32'h0000_0000);
      expect_val("int_req_eret", 0, 32'd0);
      next_cycle();

      // overflow in delay slot; concurrent mtc0 EPC must be dropped
      quiet(); a1 = 5'd12; excode_m = 5'd12; pc_m = 32'h0000_3010; bd_m = 1;
      we = 1; a2 = 5'd14; din = 32'h0000_DEAD;
      expect_val("sr_exl_cleared", 1, 32'h0000_0401);
      expect_val("epc_after_eret", 2, 32'h0000_1000);
      expect_val("int_req_exc", 0, 32'd1);
      next_cycle();

      quiet(); a1 = 5'd13; eret_m = 1;
      expect_val("cause_ov_bd", 1, 32'h8000_0030);
      expect_val("epc_ov_bd", 2, 32'h0000_300C);
      expect_val("int_req_after_exc", 0, 32'd0);
      next_cycle();

      // interrupt and exception together: interrupt wins, low PC bits dropped
      quiet(); a1 = 5'd12; hwint = 6'b000001; excode_m = 5'd4; pc_m = 32'h0000_2002;
      expect_val("sr_before_prio", 1, 32'h0000_0401);
      expect_val("int_req_prio", 0, 32'd1);
      next_cycle();

      quiet(); a1 = 5'd13; eret_m = 1;
      expect_val("cause_prio", 1, 32'h0000_0400);
      expect_val("epc_prio", 2, 32'h0000_2000);
      next_cycle();

      // mtc0 EPC with same-cycle read: old value, then aligned new value
      quiet(); a1 = 5'd14; we = 1; a2 = 5'd14; din = 32'h0000_3007;
      expect_val("dout_no_bypass", 1, 32'h0000_2000);
      expect_val("int_req_mtc0", 0, 32'd0);
      next_cycle();

      quiet(); a1 = 5'd14; we = 1; a2 = 5'd13; din = 32'hFFFF_FFFF;
      expect_val("dout_epc_new", 1, 32'h0000_3004);
      expect_val("epc_out_new", 2, 32'h0000_3004);
      next_cycle();

      quiet(); a1 = 5'd15;
      expect_val("prid", 1, 32'h0000_1234);
      next_cycle();

      quiet(); a1 = 5'd13;
      expect_val("cause_write_dropped", 1, 32'h0000_0000);
      next_cycle();

      // unmapped read, then interrupt in a delay slot
      quiet(); a1 = 5'd7; hwint = 6'b000001; pc_m = 32'h0000_4000; bd_m = 1;
      expect_val("unmapped_read", 1, 32'h0);
      expect_val("int_req_int_bd", 0, 32'd1);
      next_cycle();

      quiet(); a1 = 5'd13;
      expect_val("cause_int_bd", 1, 32'h8000_0400);
      expect_val("epc_int_bd", 2, 32'h0000_3FFC);
      expect_val("int_req_exl_hold", 0, 32'd0);
      next_cycle();

      // reset overrides eret, mtc0 and pending exception on the same edge
      quiet(); a1 = 5'd12; reset = 1; excode_m = 5'd4; eret_m = 1;
      we = 1; a2 = 5'd12; din = 32'hFFFF_FFFF; hwint = 6'h3F;
      expect_val("sr_before_reset2", 1, 32'h0000_0403);
      expect_val("int_req_reset2", 0, 32'd0);
      next_cycle();

      quiet(); a1 = 5'd12;
      expect_val("sr_reset2", 1, 32'h0);
      expect_val("epc_reset2", 2, 32'h0);
      next_cycle();

      quiet(); a1 = 5'd13;
      expect_val("cause_reset2", 1, 32'h0);
      next_cycle();

      @(negedge clk);
      #1;
      if (scb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d entries expected 0", scb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
